// File: rtl/ama_riscv_mmio_ctrl_if.sv
// Data-side MMIO bus between the core (master) and the MMIO responder (slave).
// Same shape as the dmem port: strobe, byte enables, word offset, registered read data.
interface ama_riscv_mmio_ctrl_if #(
   parameter int ADDR_W = 4
);
   logic              en;
   logic [3:0]        we;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       din;
   logic [31:0]       dout;

   modport master (output en, output we, output addr, output din, input  dout);
   modport slave  (input  en, input  we, input  addr, input  din, output dout);
endinterface

// File: rtl/ama_riscv_mmio_ctrl.sv
// MMIO responder: tohost register, 64-bit cycle/instret counters with HI snapshot,
// and a RUN/HALT machine that stops counting once software writes tohost[0]=1.
module ama_riscv_mmio_ctrl #(
   parameter int          ADDR_W     = 4,
   parameter int          CNT_W      = 64,
   parameter logic [31:0] TOHOST_RST = 32'h0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   ama_riscv_mmio_ctrl_if.slave       bus,
   input  logic                       inst_wb_nop_or_clear,
   output logic [31:0]                tohost,
   output logic                       halted,
   output logic                       mmio_reset_cnt
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [ADDR_W-1:0] A_TOHOST   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_CNT_CTRL = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_CYC_LO   = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_CYC_HI   = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_INS_LO   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_INS_HI   = ADDR_W'(5);

   function automatic logic [31:0] lane_merge(logic [31:0] old, logic [3:0] be, logic [31:0] d);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // Increment first, then overlay any written half, so the unwritten half keeps the carry.
   function automatic logic [63:0] cnt_update(logic [63:0] cur, logic inc, logic wr_lo,
                                              logic wr_hi, logic [3:0] be, logic [31:0] d);
      logic [63:0] v;
      v = cur + 64'(inc);
      if (wr_lo) v[31:0]  = lane_merge(v[31:0], be, d);
      if (wr_hi) v[63:32] = lane_merge(v[63:32], be, d);
      return v;
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d, ins_q, ins_d;
   logic [31:0]       cyc_shadow_q, ins_shadow_q;
   logic              freeze_q;
   logic [31:0]       tohost_d, dout_q, rd_data;
   logic [63:0]       cyc_ext, ins_ext;
   logic              rd, wr, count_en, clear, ctrl_wr;

   assign bus.dout = dout_q;
   assign halted   = (state_q == HALT);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cyc_ext  = 64'(cyc_q);
      ins_ext  = 64'(ins_q);
      rd       = bus.en && (bus.we == 4'b0000);
      wr       = bus.en && (bus.we != 4'b0000) && (state_q == RUN);
      count_en = (state_q == RUN) && !freeze_q;
      ctrl_wr  = wr && (bus.addr == A_CNT_CTRL) && bus.we[0];
      clear    = ctrl_wr && bus.din[0];

      cyc_d = CNT_W'(cnt_update(cyc_ext, count_en, wr && (bus.addr == A_CYC_LO),
                                wr && (bus.addr == A_CYC_HI), bus.we, bus.din));
      ins_d = CNT_W'(cnt_update(ins_ext, count_en && !inst_wb_nop_or_clear,
                                wr && (bus.addr == A_INS_LO),
                                wr && (bus.addr == A_INS_HI), bus.we, bus.din));
      if (clear) begin
         cyc_d = '0;
         ins_d = '0;
      end

      tohost_d = tohost;
      if (wr && (bus.addr == A_TOHOST)) tohost_d = lane_merge(tohost, bus.we, bus.din);

      state_d = state_q;
      if ((state_q == RUN) && tohost_d[0]) state_d = HALT;

      rd_data = 32'h0;
      case (bus.addr)
         A_TOHOST:   rd_data = tohost;
         A_CNT_CTRL: rd_data = {30'h0, freeze_q, 1'b0};
         A_CYC_LO:   rd_data = cyc_ext[31:0];
         A_CYC_HI:   rd_data = cyc_shadow_q;
         A_INS_LO:   rd_data = ins_ext[31:0];
         A_INS_HI:   rd_data = ins_shadow_q;
         default:    rd_data = 32'h0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q          <= '0;
         ins_q          <= '0;
         cyc_shadow_q   <= 32'h0;
         ins_shadow_q   <= 32'h0;
         freeze_q       <= 1'b0;
         tohost         <= TOHOST_RST;
         dout_q         <= 32'h0;
         mmio_reset_cnt <= 1'b0;
      end else begin
         cyc_q          <= cyc_d;
         ins_q          <= ins_d;
         tohost         <= tohost_d;
         mmio_reset_cnt <= clear;
         if (ctrl_wr) freeze_q <= bus.din[1];
         if (rd) begin
            dout_q <= rd_data;
            // LO reads snapshot the pre-increment HI half for a coherent 64-bit pair.
            if (bus.addr == A_CYC_LO) cyc_shadow_q <= cyc_ext[63:32];
            if (bus.addr == A_INS_LO) ins_shadow_q <= ins_ext[63:32];
         end
      end
   end

endmodule

// File: tb/tb_ama_riscv_mmio_ctrl.sv
// Directed bench for ama_riscv_mmio_ctrl: reset, counting, carry/snapshot, clear,
// freeze, unmapped/lane writes and tohost halt, with hand-computed expectations.
module tb_ama_riscv_mmio_ctrl;

   localparam logic [3:0] A_TOHOST = 4'd0, A_CTRL = 4'd1, A_CYC_LO = 4'd2,
                          A_CYC_HI = 4'd3, A_INS_LO = 4'd4, A_INS_HI = 4'd5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_wb_nop_or_clear;
   logic [31:0] tohost;
   logic        halted;
   logic        mmio_reset_cnt;
   int          checks = 0;
   int          errors = 0;

   ama_riscv_mmio_ctrl_if #(.ADDR_W(4)) bus ();

   ama_riscv_mmio_ctrl #(.ADDR_W(4), .CNT_W(64), .TOHOST_RST(32'h0)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .bus                  (bus),
      .inst_wb_nop_or_clear (inst_wb_nop_or_clear),
      .tohost               (tohost),
      .halted               (halted),
      .mmio_reset_cnt       (mmio_reset_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.en = 1'b1; bus.we = be; bus.addr = a; bus.din = d;
      tick();
      bus.en = 1'b0; bus.we = 4'h0; bus.din = 32'h0;
   endtask

   task automatic bus_read(input logic [3:0] a);
      bus.en = 1'b1; bus.we = 4'h0; bus.addr = a;
      tick();
      bus.en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      inst_wb_nop_or_clear = 1'b1;
      bus.en = 1'b0; bus.we = 4'h0; bus.addr = 4'h0; bus.din = 32'h0;
      repeat (2) tick();
      check("rst_dout",   bus.dout, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);
      rst_n = 1'b1;

      // T1: count 20 cycles, read, then async reset between edges
      repeat (20) tick();
      bus_read(A_CYC_LO);
      check("t1_cyc_20", bus.dout, 32'd20);
      #3 rst_n = 1'b0;
      #1;
      check("t1_async_dout",   bus.dout, 32'h0);
      check("t1_async_tohost", tohost, 32'h0);
      check("t1_async_halted", {31'h0, halted}, 32'h0);
      check("t1_async_pulse",  {31'h0, mmio_reset_cnt}, 32'h0);
      tick();
      rst_n = 1'b1;
      bus_read(A_CYC_LO);
      check("t1_cyc_cleared", bus.dout, 32'h0);
      bus_read(A_INS_LO);
      check("t1_ins_cleared", bus.dout, 32'h0);

      // T2: clear, then 10 cycles with 6 retires
      bus_write(A_CTRL, 32'h1, 4'b0001);
      check("t2_pulse_on", {31'h0, mmio_reset_cnt}, 32'h1);
      for (int i = 0; i < 10; i++) begin
         inst_wb_nop_or_clear = (i < 6) ? 1'b0 : 1'b1;
         tick();
         if (i == 0) check("t2_pulse_off", {31'h0, mmio_reset_cnt}, 32'h0);
      end
      inst_wb_nop_or_clear = 1'b1;
      bus_read(A_CYC_LO);
      check("t2_cyc_10", bus.dout, 32'd10);
      bus_read(A_INS_LO);
      check("t2_ins_6", bus.dout, 32'd6);
      bus_read(A_CTRL);
      check("t2_ctrl_bit0_reads_0", bus.dout, 32'h0);

      // T3: carry from LO into HI and HI snapshot
      bus_write(A_CYC_HI, 32'h0, 4'hF);
      bus_write(A_CYC_LO, 32'hFFFF_FFFE, 4'hF);
      repeat (3) tick();
      bus_read(A_CYC_LO);
      check("t3_cyc_lo", bus.dout, 32'h0000_0001);
      bus_read(A_CYC_HI);
      check("t3_cyc_hi_shadow", bus.dout, 32'h1);
      bus_read(A_INS_HI);
      check("t3_ins_hi_shadow", bus.dout, 32'h0);

      // T5: clear wins over a same-cycle retire; then freeze
      inst_wb_nop_or_clear = 1'b0;
      bus_write(A_CTRL, 32'h1, 4'b0001);
      inst_wb_nop_or_clear = 1'b1;
      check("t5_pulse_on", {31'h0, mmio_reset_cnt}, 32'h1);
      bus_read(A_CYC_LO);
      check("t5_cyc_zero", bus.dout, 32'h0);
      check("t5_pulse_off", {31'h0, mmio_reset_cnt}, 32'h0);
      bus_read(A_INS_LO);
      check("t5_ins_zero", bus.dout, 32'h0);
      bus_write(A_CTRL, 32'h2, 4'b0001);
      bus_read(A_CTRL);
      check("t5_freeze_readback", bus.dout, 32'h2);
      bus_read(A_CYC_LO);
      check("t5_frozen_a", bus.dout, 32'd3);
      bus_write(A_CTRL, 32'h0, 4'b0001);
      bus_read(A_CYC_LO);
      check("t5_frozen_b", bus.dout, 32'd3);

      // T6: unmapped address and byte-lane tohost write
      bus_write(4'd7, 32'hDEAD_BEEF, 4'hF);
      bus_read(4'd7);
      check("t6_unmapped", bus.dout, 32'h0);
      bus_write(A_TOHOST, 32'hAABB_CC00, 4'b0100);
      check("t6_tohost_lane", tohost, 32'h00BB_0000);
      check("t6_still_run", {31'h0, halted}, 32'h0);
      bus_read(A_TOHOST);
      check("t6_tohost_read", bus.dout, 32'h00BB_0000);

      // T4: tohost[0]=1 halts; later writes ignored, counters hold
      bus_write(A_TOHOST, 32'h1, 4'hF);
      check("t4_tohost", tohost, 32'h1);
      check("t4_halted", {31'h0, halted}, 32'h1);
      bus_read(A_CYC_LO);
      check("t4_cyc_a", bus.dout, 32'd9);
      repeat (3) tick();
      bus_read(A_CYC_LO);
      check("t4_cyc_held", bus.dout, 32'd9);
      bus_write(A_TOHOST, 32'h5, 4'hF);
      check("t4_tohost_ignored", tohost, 32'h1);
      bus_write(A_CTRL, 32'h1, 4'b0001);
      check("t4_clear_ignored_pulse", {31'h0, mmio_reset_cnt}, 32'h0);
      bus_read(A_CYC_LO);
      check("t4_clear_ignored_cyc", bus.dout, 32'd9);
      check("t4_still_halted", {31'h0, halted}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
